// File: rtl/warp_writeback_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : warp_writeback_pkg                                           |
// | Description : Shared constants and types for the write-back arbiter.       |
// |               XLEN default, register address width and register count      |
// |               are the values the hart and the xrf also use.                |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
package warp_writeback_pkg;

  localparam int unsigned XLEN_DEFAULT = 64;
  localparam int unsigned REG_ADDR_W   = 5;
  localparam int unsigned REG_COUNT    = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_COUNT-1:0]  reg_mask_t;

  // One bit per architectural register, set at the given address.
  function automatic reg_mask_t reg_onehot(input reg_addr_t addr);
    reg_onehot = reg_mask_t'(1) << addr;
  endfunction

endpackage
`default_nettype wire

// File: rtl/warp_writeback_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : warp_writeback_if                                            |
// | Description : Bundle between the execution units / register file and the   |
// |               write-back arbiter.                                          |
// |   i_unit_valid  [NUM_UNITS]        result valid per unit                   |
// |   o_unit_ready  [NUM_UNITS]        per-unit buffer can accept              |
// |   i_unit_rd     [NUM_UNITS*5]      destination, unit i at [5i+:5]          |
// |   i_unit_result [NUM_UNITS*XLEN]   data, unit i at [XLEN*i+:XLEN]          |
// |   o_rd_wen      [NUM_PORTS]        write enable per port                   |
// |   o_rd_addr     [NUM_PORTS*5]      write address per port                  |
// |   o_rd_wdata    [NUM_PORTS*XLEN]   write data per port                     |
// |   o_retire      [32]               destinations written this cycle         |
// | slave  modport : arbiter view.  master modport : unit/xrf side view.       |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
interface warp_writeback_if
  import warp_writeback_pkg::*;
#(
  parameter int NUM_UNITS = 4,
  parameter int NUM_PORTS = 2,
  parameter int XLEN      = XLEN_DEFAULT
);
  logic [NUM_UNITS-1:0]            i_unit_valid;
  logic [NUM_UNITS-1:0]            o_unit_ready;
  logic [NUM_UNITS*REG_ADDR_W-1:0] i_unit_rd;
  logic [NUM_UNITS*XLEN-1:0]       i_unit_result;
  logic [NUM_PORTS-1:0]            o_rd_wen;
  logic [NUM_PORTS*REG_ADDR_W-1:0] o_rd_addr;
  logic [NUM_PORTS*XLEN-1:0]       o_rd_wdata;
  logic [REG_COUNT-1:0]            o_retire;

  modport master (
    output i_unit_valid, i_unit_rd, i_unit_result,
    input  o_unit_ready, o_rd_wen, o_rd_addr, o_rd_wdata, o_retire
  );

  modport slave (
    input  i_unit_valid, i_unit_rd, i_unit_result,
    output o_unit_ready, o_rd_wen, o_rd_addr, o_rd_wdata, o_retire
  );
endinterface
`default_nettype wire

// File: rtl/warp_wb_select.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : warp_wb_select                                               |
// | Description : Find-first-set over i_req starting at i_start and wrapping   |
// |               modulo N. Exclusions are applied by the caller in i_req.     |
// |   i_req   [N]      candidate mask                                          |
// |   i_start [IW]     first index to examine                                  |
// |   o_valid          a candidate was found                                   |
// |   o_idx   [IW]     index of the first candidate in scan order              |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module warp_wb_select #(
  parameter int N = 4
) (
  input  logic [N-1:0]         i_req,
  input  logic [$clog2(N)-1:0] i_start,
  output logic                 o_valid,
  output logic [$clog2(N)-1:0] o_idx
);
  localparam int IW = $clog2(N);

  always_comb begin
    int j;
    o_valid = 1'b0;
    o_idx   = '0;
    j       = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(i_start) + k;
      if (j >= N) j = j - N;
      if (!o_valid && i_req[j]) begin
        o_valid = 1'b1;
        o_idx   = IW'(j);
      end
    end
  end
endmodule
`default_nettype wire

// File: rtl/warp_writeback.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : warp_writeback                                               |
// | Description : Write-back arbiter. One holding buffer per execution unit;   |
// |               up to NUM_PORTS buffers granted per cycle onto registered    |
// |               register-file write ports, never two with the same rd.       |
// |   i_clk, i_rst_n (async, active-low)                                       |
// |   bus : warp_writeback_if.slave (unit handshake + write ports + retire)    |
// | Build option : WARP_WB_RR_EN selects round-robin priority; when undefined  |
// |               the scan always starts at unit 0 (fixed priority).           |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module warp_writeback
  import warp_writeback_pkg::*;
#(
  parameter int NUM_UNITS = 4,
  parameter int NUM_PORTS = 2,
  parameter int XLEN      = XLEN_DEFAULT
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  warp_writeback_if.slave   bus
);
  localparam int IW = $clog2(NUM_UNITS);

  logic [NUM_UNITS-1:0] full_q, full_d;
  reg_addr_t            rd_q   [NUM_UNITS];
  reg_addr_t            rd_d   [NUM_UNITS];
  logic [XLEN-1:0]      data_q [NUM_UNITS];
  logic [XLEN-1:0]      data_d [NUM_UNITS];

  logic [NUM_PORTS-1:0] wen_q, wen_d;
  reg_addr_t            addr_q  [NUM_PORTS];
  reg_addr_t            addr_d  [NUM_PORTS];
  logic [XLEN-1:0]      wdata_q [NUM_PORTS];
  logic [XLEN-1:0]      wdata_d [NUM_PORTS];

  logic [IW-1:0]        scan_start;
  logic [NUM_PORTS-1:0] sel_valid;
  logic [IW-1:0]        sel_idx [NUM_PORTS];
  logic [NUM_UNITS-1:0] grant;
  logic [NUM_UNITS-1:0] ready;

`ifdef WARP_WB_RR_EN
  logic [IW-1:0] ptr_q, ptr_d;
  assign scan_start = ptr_q;
`else
  assign scan_start = '0;
`endif

  // Selection chain. Each stage removes the previous winner and every buffer
  // sharing its rd, so the ports never carry the same destination together.
  // Because later stages see a subset of the earlier candidates, stage p
  // finds the (p+1)-th eligible buffer in scan order.
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_stage
    logic [NUM_UNITS-1:0] excl_cur;
    logic [NUM_UNITS-1:0] excl_next;
    logic                 stage_valid;
    logic [IW-1:0]        stage_idx;

    if (p == 0) begin : g_head
      assign excl_cur = '0;
    end else begin : g_link
      assign excl_cur = g_stage[p-1].excl_next;
    end

    warp_wb_select #(.N(NUM_UNITS)) u_select (
      .i_req   (full_q & ~excl_cur),
      .i_start (scan_start),
      .o_valid (stage_valid),
      .o_idx   (stage_idx)
    );

    always_comb begin
      excl_next = excl_cur;
      if (stage_valid) begin
        for (int i = 0; i < NUM_UNITS; i++) begin
          if (rd_q[i] == rd_q[stage_idx]) excl_next[i] = 1'b1;
        end
      end
    end

    assign sel_valid[p] = stage_valid;
    assign sel_idx[p]   = stage_idx;
  end

  always_comb begin
    grant = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (sel_valid[p]) grant[sel_idx[p]] = 1'b1;
    end
  end

  // A granted buffer frees at this edge, so it can take a new result now.
  assign ready            = ~full_q | grant;
  assign bus.o_unit_ready = ready;

  // Buffers: rd 0 results are accepted but never stored.
  always_comb begin
    full_d = full_q;
    rd_d   = rd_q;
    data_d = data_q;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (bus.i_unit_valid[i] && ready[i] &&
          bus.i_unit_rd[REG_ADDR_W*i +: REG_ADDR_W] != '0) begin
        full_d[i] = 1'b1;
        rd_d[i]   = bus.i_unit_rd[REG_ADDR_W*i +: REG_ADDR_W];
        data_d[i] = bus.i_unit_result[XLEN*i +: XLEN];
      end else if (grant[i]) begin
        full_d[i] = 1'b0;
      end
    end
  end

  // Write ports: idle ports drop wen but keep their last addr/data.
  always_comb begin
    wen_d   = sel_valid;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (sel_valid[p]) begin
        addr_d[p]  = rd_q[sel_idx[p]];
        wdata_d[p] = data_q[sel_idx[p]];
      end
    end
  end

`ifdef WARP_WB_RR_EN
  // The highest-numbered valid stage holds the last grant of the scan.
  always_comb begin
    ptr_d = ptr_q;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (sel_valid[p]) begin
        ptr_d = (sel_idx[p] == IW'(NUM_UNITS - 1)) ? '0 : sel_idx[p] + 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      full_q <= '0;
      wen_q  <= '0;
      for (int i = 0; i < NUM_UNITS; i++) begin
        rd_q[i]   <= '0;
        data_q[i] <= '0;
      end
      for (int p = 0; p < NUM_PORTS; p++) begin
        addr_q[p]  <= '0;
        wdata_q[p] <= '0;
      end
`ifdef WARP_WB_RR_EN
      ptr_q <= '0;
`endif
    end else begin
      full_q  <= full_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
`ifdef WARP_WB_RR_EN
      ptr_q <= ptr_d;
`endif
    end
  end

  logic [NUM_PORTS*REG_ADDR_W-1:0] addr_flat;
  logic [NUM_PORTS*XLEN-1:0]       wdata_flat;
  reg_mask_t                       retire;

  always_comb begin
    addr_flat  = '0;
    wdata_flat = '0;
    retire     = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      addr_flat[REG_ADDR_W*p +: REG_ADDR_W] = addr_q[p];
      wdata_flat[XLEN*p +: XLEN]            = wdata_q[p];
      if (wen_q[p]) retire = retire | reg_onehot(addr_q[p]);
    end
  end

  assign bus.o_rd_wen   = wen_q;
  assign bus.o_rd_addr  = addr_flat;
  assign bus.o_rd_wdata = wdata_flat;
  assign bus.o_retire   = retire;

endmodule
`default_nettype wire

// File: tb/tb_warp_writeback.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_warp_writeback                                            |
// | Description : Self-checking bench for warp_writeback (4 units, 2 ports).   |
// |               A reference model tracks buffer contents, the priority       |
// |               start point and the expected write-port registers.           |
// |               Honours WARP_WB_RR_EN the same way as the design.            |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_warp_writeback;
  import warp_writeback_pkg::*;

  localparam int NU = 4;
  localparam int NP = 2;
  localparam int XL = 64;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  warp_writeback_if #(.NUM_UNITS(NU), .NUM_PORTS(NP), .XLEN(XL)) bus ();

  warp_writeback #(.NUM_UNITS(NU), .NUM_PORTS(NP), .XLEN(XL)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [NU-1:0]   m_full;
  logic [4:0]      m_rd   [NU];
  logic [XL-1:0]   m_data [NU];
  int              m_ptr;
  logic [NP-1:0]   e_wen;
  logic [4:0]      e_addr  [NP];
  logic [XL-1:0]   e_wdata [NP];

  int accepted;
  int written;
  int gcount [NU];

  task automatic model_reset();
    m_full = '0;
    m_ptr  = 0;
    e_wen  = '0;
    for (int i = 0; i < NU; i++) begin
      m_rd[i]   = '0;
      m_data[i] = '0;
    end
    for (int p = 0; p < NP; p++) begin
      e_addr[p]  = '0;
      e_wdata[p] = '0;
    end
  endtask

  task automatic set_unit(input int u, input logic v, input logic [4:0] rd,
                          input logic [XL-1:0] d);
    bus.i_unit_valid[u]        = v;
    bus.i_unit_rd[5*u +: 5]    = rd;
    bus.i_unit_result[XL*u +: XL] = d;
  endtask

  task automatic idle_inputs();
    bus.i_unit_valid = '0;
  endtask

  function automatic logic [XL-1:0] tag_data(input int u);
    tag_data = {8'(u), 24'($urandom), 32'($urandom)};
  endfunction

  // Called at a negedge with inputs already driven: compares the DUT against
  // the model, advances the model across the coming edge, then returns at the
  // next negedge.
  task automatic cycle();
    logic [31:0]   exp_ret;
    logic [31:0]   used;
    logic [NU-1:0] gnt;
    logic [NU-1:0] exp_ready;
    int            gu [NP];
    int            n;
    int            start;
    int            u;
    int            last;
    int            tag;

    exp_ret = '0;
    for (int p = 0; p < NP; p++) begin
      if (e_wen[p]) exp_ret = exp_ret | (32'd1 << e_addr[p]);
      checks++;
      if (bus.o_rd_wen[p] !== e_wen[p]) begin
        failures++;
        $display("FAIL wen[%0d] t=%0t: got %b want %b", p, $time, bus.o_rd_wen[p], e_wen[p]);
      end
      checks++;
      if (bus.o_rd_addr[5*p +: 5] !== e_addr[p]) begin
        failures++;
        $display("FAIL addr[%0d] t=%0t: got %0d want %0d", p, $time, bus.o_rd_addr[5*p +: 5], e_addr[p]);
      end
      checks++;
      if (bus.o_rd_wdata[XL*p +: XL] !== e_wdata[p]) begin
        failures++;
        $display("FAIL wdata[%0d] t=%0t: got %h want %h", p, $time, bus.o_rd_wdata[XL*p +: XL], e_wdata[p]);
      end
    end
    checks++;
    if (bus.o_retire !== exp_ret) begin
      failures++;
      $display("FAIL retire t=%0t: got %h want %h", $time, bus.o_retire, exp_ret);
    end
    // No register may be written by two ports at once.
    for (int a = 0; a < NP; a++) begin
      for (int b = a + 1; b < NP; b++) begin
        checks++;
        if (bus.o_rd_wen[a] && bus.o_rd_wen[b] &&
            bus.o_rd_addr[5*a +: 5] == bus.o_rd_addr[5*b +: 5]) begin
          failures++;
          $display("FAIL dup_addr t=%0t: ports %0d,%0d both write %0d want distinct", $time, a, b, bus.o_rd_addr[5*a +: 5]);
        end
      end
    end
    for (int p = 0; p < NP; p++) begin
      if (bus.o_rd_wen[p] === 1'b1) begin
        written++;
        tag = int'(bus.o_rd_wdata[XL*p+56 +: 8]);
        if (tag < NU) gcount[tag]++;
      end
    end

    // Grant decision: walk units in priority order, skip empties and rds
    // already taken this cycle, stop when the ports run out.
    gnt  = '0;
    used = '0;
    n    = 0;
    last = -1;
    for (int p = 0; p < NP; p++) gu[p] = 0;
`ifdef WARP_WB_RR_EN
    start = m_ptr;
`else
    start = 0;
`endif
    for (int k = 0; k < NU; k++) begin
      u = (start + k) % NU;
      if (m_full[u] && !used[m_rd[u]] && n < NP) begin
        gnt[u]        = 1'b1;
        used[m_rd[u]] = 1'b1;
        gu[n]         = u;
        n++;
        last = u;
      end
    end
    exp_ready = ~m_full | gnt;
    checks++;
    if (bus.o_unit_ready !== exp_ready) begin
      failures++;
      $display("FAIL ready t=%0t: got %b want %b", $time, bus.o_unit_ready, exp_ready);
    end

    for (int p = 0; p < NP; p++) begin
      if (p < n) begin
        e_wen[p]   = 1'b1;
        e_addr[p]  = m_rd[gu[p]];
        e_wdata[p] = m_data[gu[p]];
      end else begin
        e_wen[p] = 1'b0;
      end
    end
    for (int i = 0; i < NU; i++) begin
      if (bus.i_unit_valid[i] && exp_ready[i] && bus.i_unit_rd[5*i +: 5] != 5'd0) begin
        m_full[i] = 1'b1;
        m_rd[i]   = bus.i_unit_rd[5*i +: 5];
        m_data[i] = bus.i_unit_result[XL*i +: XL];
        accepted++;
      end else if (gnt[i]) begin
        m_full[i] = 1'b0;
      end
    end
    if (n > 0) m_ptr = (last + 1) % NU;

    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain(input int n);
    idle_inputs();
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic test_reset();
    bus.i_unit_valid  = '1;
    bus.i_unit_rd     = {5'd4, 5'd3, 5'd2, 5'd1};
    bus.i_unit_result = '1;
    rst_n = 1'b0;
    model_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (bus.o_rd_wen !== '0 || bus.o_retire !== '0) begin
        failures++;
        $display("FAIL reset_wen: got wen=%b retire=%h want 0/0", bus.o_rd_wen, bus.o_retire);
      end
      checks++;
      if (bus.o_rd_addr !== '0 || bus.o_rd_wdata !== '0) begin
        failures++;
        $display("FAIL reset_port: got addr=%h data=%h want 0", bus.o_rd_addr, bus.o_rd_wdata);
      end
      checks++;
      if (bus.o_unit_ready !== '1) begin
        failures++;
        $display("FAIL reset_ready: got %b want 1111", bus.o_unit_ready);
      end
    end
    idle_inputs();
    rst_n = 1'b1;
    cycle();
  endtask

  task automatic test_single();
    drain(4);
    set_unit(0, 1'b1, 5'd5, 64'h1234);
    cycle();
    idle_inputs();
    cycle();
    checks++;
    if (bus.o_rd_wen[0] !== 1'b1 || bus.o_rd_addr[4:0] !== 5'd5 || bus.o_rd_wdata[63:0] !== 64'h1234) begin
      failures++;
      $display("FAIL single_port0: got wen=%b addr=%0d data=%h want 1/5/1234", bus.o_rd_wen[0], bus.o_rd_addr[4:0], bus.o_rd_wdata[63:0]);
    end
    checks++;
    if (bus.o_retire !== 32'h20) begin
      failures++;
      $display("FAIL single_retire: got %h want 00000020", bus.o_retire);
    end
    drain(2);
  endtask

  task automatic test_rd0();
    drain(3);
    for (int c = 0; c < 4; c++) begin
      set_unit(3, 1'b1, 5'd0, tag_data(3));
      cycle();
      checks++;
      if (bus.o_unit_ready[3] !== 1'b1 || bus.o_rd_wen !== '0 || bus.o_retire !== '0) begin
        failures++;
        $display("FAIL rd0: got ready3=%b wen=%b retire=%h want 1/00/0", bus.o_unit_ready[3], bus.o_rd_wen, bus.o_retire);
      end
    end
    drain(2);
  endtask

  task automatic test_conflict();
    logic [XL-1:0] da, db;
    logic [XL-1:0] got [2];
    int            hits;
    drain(3);
    da = tag_data(1);
    db = tag_data(2);
    set_unit(1, 1'b1, 5'd7, da);
    set_unit(2, 1'b1, 5'd7, db);
    cycle();
    idle_inputs();
    for (int c = 0; c < 2; c++) begin
      cycle();
      hits   = 0;
      got[c] = '0;
      for (int p = 0; p < NP; p++) begin
        if (bus.o_rd_wen[p] && bus.o_rd_addr[5*p +: 5] == 5'd7) begin
          hits++;
          got[c] = bus.o_rd_wdata[XL*p +: XL];
        end
      end
      checks++;
      if (hits != 1) begin
        failures++;
        $display("FAIL conflict_cycle%0d: got %0d writes to r7 want 1", c, hits);
      end
    end
    checks++;
    if (!((got[0] == da && got[1] == db) || (got[0] == db && got[1] == da))) begin
      failures++;
      $display("FAIL conflict_data: got %h,%h want {%h,%h}", got[0], got[1], da, db);
    end
    drain(2);
  endtask

  task automatic test_all_valid();
    logic [NU-1:0] seen0, seen1;
    drain(3);
    for (int i = 0; i < NU; i++) gcount[i] = 0;
    seen0 = '0;
    seen1 = '0;
    for (int c = 0; c < 20; c++) begin
      for (int u = 0; u < NU; u++) set_unit(u, 1'b1, 5'(u + 1), tag_data(u));
      cycle();
      seen0 = seen0 | ~bus.o_unit_ready;
      seen1 = seen1 | bus.o_unit_ready;
    end
`ifdef WARP_WB_RR_EN
    checks++;
    if ((seen0 & seen1) !== '1) begin
      failures++;
      $display("FAIL all_valid_toggle: got toggled=%b want 1111", seen0 & seen1);
    end
    checks++;
    if (gcount[0] == 0 || gcount[1] == 0 || gcount[2] == 0 || gcount[3] == 0) begin
      failures++;
      $display("FAIL all_valid_share: got %0d %0d %0d %0d want all nonzero", gcount[0], gcount[1], gcount[2], gcount[3]);
    end
`else
    checks++;
    if (gcount[2] != 0 || gcount[3] != 0 || gcount[0] == 0 || gcount[1] == 0) begin
      failures++;
      $display("FAIL all_valid_fixed: got %0d %0d %0d %0d want units 2,3 zero", gcount[0], gcount[1], gcount[2], gcount[3]);
    end
`endif
    drain(4);
  endtask

  task automatic test_priority();
    drain(3);
    for (int i = 0; i < NU; i++) gcount[i] = 0;
    for (int c = 0; c < 16; c++) begin
      for (int u = 0; u < 3; u++) set_unit(u, 1'b1, 5'(u + 1), tag_data(u));
      cycle();
    end
`ifdef WARP_WB_RR_EN
    checks++;
    if (gcount[2] == 0) begin
      failures++;
      $display("FAIL priority_rr: got unit2 grants=%0d want >0", gcount[2]);
    end
`else
    checks++;
    if (gcount[2] != 0 || gcount[0] == 0) begin
      failures++;
      $display("FAIL priority_fixed: got unit0=%0d unit2=%0d want >0 / 0", gcount[0], gcount[2]);
    end
`endif
    drain(4);
  endtask

  task automatic test_random();
    drain(3);
    accepted = 0;
    written  = 0;
    for (int c = 0; c < 400; c++) begin
      for (int u = 0; u < NU; u++) begin
        set_unit(u, 1'($urandom_range(0, 9) < 6), 5'($urandom_range(0, 7)), tag_data(u));
      end
      cycle();
    end
    drain(8);
    checks++;
    if (accepted != written) begin
      failures++;
      $display("FAIL random_count: got written=%0d want %0d", written, accepted);
    end
  endtask

  task automatic test_reset_mid();
    drain(3);
    set_unit(3, 1'b1, 5'd12, tag_data(3));
    cycle();
    idle_inputs();
    set_unit(0, 1'b1, 5'd9,  tag_data(0));
    set_unit(1, 1'b1, 5'd10, tag_data(1));
    set_unit(2, 1'b1, 5'd11, tag_data(2));
    cycle();
    idle_inputs();
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.o_rd_wen !== '0 || bus.o_retire !== '0) begin
      failures++;
      $display("FAIL midreset_wen: got wen=%b retire=%h want 0/0", bus.o_rd_wen, bus.o_retire);
    end
    checks++;
    if (bus.o_unit_ready !== '1) begin
      failures++;
      $display("FAIL midreset_ready: got %b want 1111", bus.o_unit_ready);
    end
    @(posedge clk);
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    written = 0;
    drain(6);
    checks++;
    if (written != 0) begin
      failures++;
      $display("FAIL midreset_stale: got %0d writes want 0", written);
    end
  endtask

  initial begin
    bus.i_unit_valid  = '0;
    bus.i_unit_rd     = '0;
    bus.i_unit_result = '0;
    accepted = 0;
    written  = 0;
    for (int i = 0; i < NU; i++) gcount[i] = 0;
    @(negedge clk);
    test_reset();
    test_single();
    test_rd0();
    test_conflict();
    test_all_valid();
    test_priority();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/warp_writeback.md
# warp_writeback

Parametrised write-back arbiter between the integer execution units and the register file write ports. It buffers one result per unit and grants up to NUM_PORTS results per cycle using round-robin priority. Granted results drive registered write ports and a combined retire mask back to issue. Backpressure reaches each execution unit through a real ready signal.

## Interface
- NUM_UNITS, 4: number of execution-unit result channels (2..8)
- NUM_PORTS, 2: number of register file write ports (1..NUM_UNITS)
- XLEN, 64: result data width
- i_clk  in  1  clock; all state updates on rising edge
- i_rst_n  in  1  reset; asynchronous, active-low
- i_unit_valid  in  NUM_UNITS  result valid, one bit per unit
- o_unit_ready  out  NUM_UNITS  buffer can accept a result this cycle
- i_unit_rd  in  NUM_UNITS*5  destination register, unit i at [5i+:5]
- i_unit_result  in  NUM_UNITS*XLEN  result data, unit i at [XLEN*i+:XLEN]
- o_rd_wen  out  NUM_PORTS  write enable per port
- o_rd_addr  out  NUM_PORTS*5  write address per port
- o_rd_wdata  out  NUM_PORTS*XLEN  write data per port
- o_retire  out  32  one-hot-per-register mask of destinations written this cycle

## Operation
- Per unit: one-entry holding buffer (full flag, rd, data).
- Accept on i_unit_valid[i] & o_unit_ready[i]. o_unit_ready[i] = !full[i] | grant[i]. It depends only on registered state, never on i_unit_valid.
- rd == 0: the result is accepted and discarded. The buffer does not fill and no port is used.
- Grant: full buffers are scanned starting at the priority pointer and wrapping modulo NUM_UNITS. The first eligible buffer takes port 0, the next port 1, and so on, up to NUM_PORTS grants.
- rd conflict: a buffer whose rd equals an rd already granted earlier in the same scan is not eligible this cycle. It retains its data.
- A granted buffer clears at the edge. If the same unit handshakes in the same cycle, the buffer reloads with the new result and stays full.
- Pointer: after any grant, the pointer moves to one past the last granted unit, modulo NUM_UNITS. With no grant it is unchanged.
- Port outputs are registered:
  - o_rd_wen[p] is high in the cycle after the grant, with the granted rd and data.
  - Unused ports drive wen 0. addr and data hold their previous values.
- o_retire is the OR of (1 << o_rd_addr[p]) over ports with o_rd_wen[p] high. It is combinational from the port registers.

## Timing
- Reset values: all full flags 0, pointer 0, o_rd_wen 0, o_rd_addr 0, o_rd_wdata 0, o_retire 0. o_unit_ready is all 1s both during and after reset.
- No capture occurs while i_rst_n is low. Assertion mid-operation discards buffered results and in-flight port values immediately.
- Latency: a result accepted at edge k is granted in the cycle after k. o_rd_wen goes high after edge k+1, and the xrf writes at edge k+2.
- Throughput: each unit sustains 1 result/cycle while it is granted every cycle. Aggregate throughput is at most NUM_PORTS results/cycle.
- Worst-case wait with WARP_WB_RR_EN: a full buffer is granted within ceil(NUM_UNITS/NUM_PORTS) cycles, excluding rd-conflict stalls.
- At most one grant per rd per cycle, so the xrf never sees two ports writing the same register.

## Configuration
- WARP_WB_RR_EN defined: round-robin pointer as described above.
- Not defined: fixed priority, unit 0 highest. The scan always starts at unit 0, the pointer register is absent, and starvation of high-index units is permitted.

## Structure
- Shared defines header: XLEN default, register address width (5), and register count (32). The hart and xrf use the same values.
- One sub-module, warp_wb_select: a find-first-set from a rotating start index with an exclusion mask. It is instantiated NUM_PORTS times in a chain; each stage excludes the previous grants and any buffer whose rd matches a previous grant.

## Test plan
- Reset, then unit 0 sends rd=5, data=0x1234 -> port 0 wen=1, addr=5, data=0x1234 two edges after acceptance; o_retire=0x20.
- NUM_UNITS=4, NUM_PORTS=2, all four units valid every cycle with distinct rds (1..4) -> grants alternate {0,1}, {2,3}; every o_unit_ready toggles; no result is lost or duplicated.
- Units 1 and 2 both full with rd=7 -> only one is granted in the first cycle and the other in the next; o_rd_wen never shows two ports with addr 7 together.
- Unit 3 sends rd=0 -> it is accepted, no o_rd_wen, o_retire stays 0, and o_unit_ready[3] stays 1.
- Without WARP_WB_RR_EN, units 0 and 1 hold continuous valid and NUM_PORTS=1 -> unit 1 is never granted while unit 0 stays valid. With the macro defined, grants alternate 0,1,0,1.
- i_rst_n dropped while three buffers are full -> o_rd_wen=0 immediately; after release, no stale writes occur and ready is all 1s.
